// File: rtl/xpt2046_responder.sv
// ---------------------------------------------------------------------------
// xpt2046_responder
//
// Device-side emulation of the XPT2046 resistive touch controller SPI port.
// The block listens to the master (touch_basemod) on TP_CS_N/TP_CLK/TP_DI,
// decodes the 8-bit control byte and answers on TP_DO with a 12-bit (or
// 8-bit) conversion result taken from the supplied coordinates.
//
// Optional build macro:
//   XPT_PRESSURE_EN - adds iZ1/iZ2 inputs answered on channels 011 and 100.
//                     Without it those channels read back as zero.
//
// Ports:
//   CLOCK    system clock, at least 8x the TP_CLK rate
//   RESET    synchronous active-low reset
//   TP_CS_N  chip select from master, active low
//   TP_CLK   serial clock from master
//   TP_DI    serial data from master
//   TP_DO    serial data to master (changes after TP_CLK falls)
//   TP_IRQ   pen interrupt, active low, registered
//   iPress   1 = panel touched
//   iX       12-bit X coordinate (channel 101)
//   iY       12-bit Y coordinate (channel 001)
//   iZ1/iZ2  pressure readings (only with XPT_PRESSURE_EN)
//   oCmd     last complete control byte
//   oDone    one-cycle pulse on the rise where the master samples the LSB
// ---------------------------------------------------------------------------
module xpt2046_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_CLKS  = 16
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        TP_CS_N,
   input  logic        TP_CLK,
   input  logic        TP_DI,
   output logic        TP_DO,
   output logic        TP_IRQ,
   input  logic        iPress,
   input  logic [11:0] iX,
   input  logic [11:0] iY,
`ifdef XPT_PRESSURE_EN
   input  logic [11:0] iZ1,
   input  logic [11:0] iZ2,
`endif
   output logic [7:0]  oCmd,
   output logic        oDone
);

   localparam int CW = $clog2(FRAME_CLKS + 1);
   localparam logic [CW-1:0] FRAME_END = CW'(FRAME_CLKS);

   typedef enum logic [2:0] {IDLE, HUNT, CMD, BUSY, DATA, TAIL} state_t;

   state_t            state;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] di_sync;
   logic [SYNC_STAGES:0]   clk_sync;

   logic              cs_high;
   logic              di_bit;
   logic              clk_rise;
   logic              clk_fall;

   logic [6:0]        shreg;
   logic [2:0]        bit_cnt;
   logic [11:0]       res_sh;
   logic              eight_bit;
   logic [3:0]        data_cnt;
   logic [3:0]        nbits;
   logic [CW-1:0]     rise_cnt;
   logic [CW-1:0]     rise_inc;
   logic              irq_en;

   logic [7:0]        cmd_byte;
   logic [11:0]       raw_word;
   logic [11:0]       latch_word;

   // Bring the three master signals into the CLOCK domain. The clock chain
   // carries one extra flop so the edge detector can compare the newest
   // synchronised sample with the one before it.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         cs_sync  <= '1;
         di_sync  <= '0;
         clk_sync <= '0;
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], TP_CS_N};
         di_sync  <= {di_sync[SYNC_STAGES-2:0], TP_DI};
         clk_sync <= {clk_sync[SYNC_STAGES-1:0], TP_CLK};
      end
   end

   assign cs_high  = cs_sync[SYNC_STAGES-1];
   assign di_bit   = di_sync[SYNC_STAGES-1];
   assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES];
   assign clk_fall = ~clk_sync[SYNC_STAGES-1] & clk_sync[SYNC_STAGES];

   // Decode the byte that would be complete if this rise carries bit 8, pick
   // the channel value and, in 8-bit mode, keep only its top bits left
   // aligned so the same MSB-first shifter serves both widths. The rise
   // counter saturates instead of wrapping so a long tail cannot re-trigger.
   always_comb begin
      cmd_byte = {shreg, di_bit};
      raw_word = '0;
      case (cmd_byte[6:4])
         3'b101:  raw_word = iX;
         3'b001:  raw_word = iY;
`ifdef XPT_PRESSURE_EN
         3'b011:  raw_word = iZ1;
         3'b100:  raw_word = iZ2;
`endif
         default: raw_word = '0;
      endcase
      latch_word = cmd_byte[3] ? {raw_word[11:4], 4'b0000} : raw_word;
      rise_inc   = (rise_cnt == '1) ? rise_cnt : rise_cnt + CW'(1);
      nbits      = eight_bit ? 4'd8 : 4'd12;
   end

   // Protocol engine. A high chip select overrides everything, including any
   // TP_CLK edge seen in the same cycle. Outside of that, the byte is
   // collected on rises, the answer is driven on falls, and the frame ends
   // after FRAME_CLKS rises counted from the end of the control byte.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state     <= IDLE;
         TP_DO     <= 1'b0;
         TP_IRQ    <= 1'b1;
         oCmd      <= '0;
         oDone     <= 1'b0;
         irq_en    <= 1'b1;
         shreg     <= '0;
         bit_cnt   <= '0;
         res_sh    <= '0;
         eight_bit <= 1'b0;
         data_cnt  <= '0;
         rise_cnt  <= '0;
      end else begin
         oDone  <= 1'b0;
         TP_IRQ <= ~(iPress & irq_en & cs_high);
         if (cs_high) begin
            state <= IDLE;
            TP_DO <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= HUNT;
               end
               HUNT: begin
                  if (clk_fall) TP_DO <= 1'b0;
                  // Leading zeros before the start bit are simply skipped.
                  if (clk_rise && di_bit) begin
                     shreg   <= 7'd1;
                     bit_cnt <= 3'd1;
                     state   <= CMD;
                  end
               end
               CMD: begin
                  if (clk_fall) TP_DO <= 1'b0;
                  if (clk_rise) begin
                     if (bit_cnt == 3'd7) begin
                        oCmd      <= cmd_byte;
                        irq_en    <= ~cmd_byte[0];
                        res_sh    <= latch_word;
                        eight_bit <= cmd_byte[3];
                        data_cnt  <= '0;
                        rise_cnt  <= '0;
                        state     <= BUSY;
                     end else begin
                        shreg   <= {shreg[5:0], di_bit};
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               BUSY: begin
                  if (clk_rise) rise_cnt <= rise_inc;
                  // The first fall after the byte carries the null bit.
                  if (clk_fall) begin
                     TP_DO <= 1'b0;
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (clk_fall && data_cnt != nbits) begin
                     TP_DO    <= res_sh[11];
                     res_sh   <= {res_sh[10:0], 1'b0};
                     data_cnt <= data_cnt + 4'd1;
                  end
                  // Once every bit is on the wire, the next rise is the one
                  // on which the master takes the LSB.
                  if (clk_rise) begin
                     rise_cnt <= rise_inc;
                     if (data_cnt == nbits) begin
                        oDone <= 1'b1;
                        state <= TAIL;
                     end
                  end
               end
               TAIL: begin
                  if (clk_fall) TP_DO <= 1'b0;
                  if (clk_rise) begin
                     rise_cnt <= rise_inc;
                     if (rise_inc >= FRAME_END) state <= HUNT;
                  end
               end
               default: begin
                  state <= IDLE;
                  TP_DO <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xpt2046_responder.sv
// ---------------------------------------------------------------------------
// tb_xpt2046_responder
//
// Self-checking bench for xpt2046_responder. The bench plays the SPI master
// (TP_CLK at 1/16 of CLOCK), sends control bytes and collects 16 read bits
// per command. Expected read words come from the master-side view of the
// device: the channel value shifted into a 16-bit word behind one null bit.
// ---------------------------------------------------------------------------
module tb_xpt2046_responder;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 8;

   logic        CLOCK;
   logic        RESET;
   logic        TP_CS_N;
   logic        TP_CLK;
   logic        TP_DI;
   logic        TP_DO;
   logic        TP_IRQ;
   logic        iPress;
   logic [11:0] iX;
   logic [11:0] iY;
   logic [7:0]  oCmd;
   logic        oDone;

   int errors;
   int checks;
   int done_cnt;
   int done_rise;
   int frame_rise;

   xpt2046_responder #(
      .SYNC_STAGES(SYNC_STAGES),
      .FRAME_CLKS (16)
   ) dut (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .TP_CS_N(TP_CS_N),
      .TP_CLK (TP_CLK),
      .TP_DI  (TP_DI),
      .TP_DO  (TP_DO),
      .TP_IRQ (TP_IRQ),
      .iPress (iPress),
      .iX     (iX),
      .iY     (iY),
      .oCmd   (oCmd),
      .oDone  (oDone)
   );

   // Free-running system clock.
   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Count every cycle oDone is high and remember which master rise it
   // followed, so both a stretched pulse and a misplaced pulse show up.
   always @(negedge CLOCK) begin
      if (oDone === 1'b1) begin
         done_cnt  = done_cnt + 1;
         done_rise = frame_rise;
      end
   end

   // Master-side view of one command: 16 bits read after the control byte.
   function automatic logic [15:0] model_read(input logic [7:0] cmd,
                                              input logic [11:0] x,
                                              input logic [11:0] y);
      int ch;
      int v;
      ch = int'(cmd[6:4]);
      if (ch == 5)      v = int'(x);
      else if (ch == 1) v = int'(y);
      else              v = 0;
      if (cmd[3]) return 16'((v / 16) * 128);
      else        return 16'(v * 8);
   endfunction

   // Rise number within a command frame on which the LSB is sampled.
   function automatic int model_done_rise(input logic [7:0] cmd);
      return cmd[3] ? 9 + 8 : 9 + 12;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   // One master bit: drop TP_CLK and present DI, then sample TP_DO and raise.
   task automatic tp_bit(input logic di, output logic dout);
      TP_CLK = 1'b0;
      TP_DI  = di;
      wait_cycles(HALF);
      dout       = TP_DO;
      frame_rise = frame_rise + 1;
      TP_CLK     = 1'b1;
      wait_cycles(HALF);
   endtask

   task automatic applyStimulus(input logic [7:0] bits, input int count);
      logic b;
      for (int i = 7; i > 7 - count; i--) tp_bit(bits[i], b);
   endtask

   task automatic cs_low();
      TP_CS_N = 1'b0;
      wait_cycles(6);
   endtask

   task automatic cs_high();
      TP_CS_N = 1'b1;
      wait_cycles(6);
   endtask

   // Full command: 8 control bits then 16 read bits. Optionally disturbs the
   // coordinate inputs mid-read to show the latched word is frozen.
   task automatic do_cmd(input logic [7:0] cmd, input logic scramble,
                         output logic [15:0] rd);
      logic b;
      frame_rise = 0;
      for (int i = 7; i >= 0; i--) tp_bit(cmd[i], b);
      for (int i = 15; i >= 0; i--) begin
         if (scramble && i == 10) begin
            iX = 12'($urandom);
            iY = 12'($urandom);
         end
         tp_bit(1'b0, b);
         rd[i] = b;
      end
   endtask

   task automatic test_reset();
      RESET   = 1'b0;
      TP_CS_N = 1'b1;
      TP_CLK  = 1'b0;
      TP_DI   = 1'b0;
      iPress  = 1'b1;
      iX      = 12'hA5C;
      iY      = 12'h123;
      wait_cycles(4);
      checks++;
      if (TP_DO !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_do: got %b expected 0", TP_DO);
      end
      checks++;
      if (TP_IRQ !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_irq: got %b expected 1", TP_IRQ);
      end
      checks++;
      if (oCmd !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_cmd: got %h expected 00", oCmd);
      end
      checks++;
      if (oDone !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_done: got %b expected 0", oDone);
      end
      iPress = 1'b0;
      RESET  = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_basic();
      logic [15:0] rd;
      iX = 12'hA5C;
      done_cnt = 0;
      cs_low();
      do_cmd(8'hD0, 1'b0, rd);
      checks++;
      if (rd !== 16'h52E0) begin
         errors++; $display("[TB] FAIL basic_read: got %h expected 52e0", rd);
      end
      checks++;
      if (TP_DO !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_do_tail: got %b expected 0", TP_DO);
      end
      cs_high();
      checks++;
      if (oCmd !== 8'hD0) begin
         errors++; $display("[TB] FAIL basic_cmd: got %h expected d0", oCmd);
      end
      checks++;
      if (done_cnt !== 1 || done_rise !== 21) begin
         errors++;
         $display("[TB] FAIL basic_done: got %0d pulses at rise %0d expected 1 at 21",
                  done_cnt, done_rise);
      end
      TP_CLK = 1'b0;
      wait_cycles(4);
   endtask

   task automatic test_irq();
      logic [15:0] rd;
      iPress = 1'b1;
      wait_cycles(SYNC_STAGES + 2);
      checks++;
      if (TP_IRQ !== 1'b0) begin
         errors++; $display("[TB] FAIL irq_idle_low: got %b expected 0", TP_IRQ);
      end
      cs_low();
      checks++;
      if (TP_IRQ !== 1'b1) begin
         errors++; $display("[TB] FAIL irq_cs_low_high: got %b expected 1", TP_IRQ);
      end
      do_cmd(8'hD1, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      wait_cycles(SYNC_STAGES + 2);
      checks++;
      if (TP_IRQ !== 1'b1) begin
         errors++; $display("[TB] FAIL irq_disabled: got %b expected 1", TP_IRQ);
      end
      cs_low();
      do_cmd(8'hD0, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      wait_cycles(SYNC_STAGES + 2);
      checks++;
      if (TP_IRQ !== 1'b0) begin
         errors++; $display("[TB] FAIL irq_reenabled: got %b expected 0", TP_IRQ);
      end
      iPress = 1'b0;
      wait_cycles(4);
   endtask

   task automatic test_modes();
      logic [15:0] rd;
      iX = 12'hA5C;
      iY = 12'h123;
      cs_low();
      do_cmd(8'h90, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (rd !== 16'h0918) begin
         errors++; $display("[TB] FAIL mode_y12: got %h expected 0918", rd);
      end
      done_cnt = 0;
      cs_low();
      do_cmd(8'hD8, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (rd !== 16'h5280) begin
         errors++; $display("[TB] FAIL mode_x8: got %h expected 5280", rd);
      end
      checks++;
      if (done_cnt !== 1 || done_rise !== 17) begin
         errors++;
         $display("[TB] FAIL mode_x8_done: got %0d pulses at rise %0d expected 1 at 17",
                  done_cnt, done_rise);
      end
      wait_cycles(4);
   endtask

   task automatic test_leading_zeros();
      logic [15:0] rd;
      iX = 12'hA5C;
      cs_low();
      applyStimulus(8'h00, 8);
      do_cmd(8'hD0, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (rd !== 16'h52E0) begin
         errors++; $display("[TB] FAIL lead_zero_read: got %h expected 52e0", rd);
      end
      wait_cycles(4);
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd1;
      logic [15:0] rd2;
      iX = 12'hA5C;
      iY = 12'h123;
      done_cnt = 0;
      cs_low();
      do_cmd(8'hD0, 1'b0, rd1);
      do_cmd(8'h90, 1'b0, rd2);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (rd1 !== 16'h52E0) begin
         errors++; $display("[TB] FAIL b2b_first: got %h expected 52e0", rd1);
      end
      checks++;
      if (rd2 !== 16'h0918) begin
         errors++; $display("[TB] FAIL b2b_second: got %h expected 0918", rd2);
      end
      checks++;
      if (done_cnt !== 2) begin
         errors++; $display("[TB] FAIL b2b_done: got %0d expected 2", done_cnt);
      end
      checks++;
      if (oCmd !== 8'h90) begin
         errors++; $display("[TB] FAIL b2b_cmd: got %h expected 90", oCmd);
      end
      wait_cycles(4);
   endtask

   task automatic test_abort();
      logic [15:0] rd;
      iX = 12'hA5C;
      iY = 12'h123;
      done_cnt = 0;
      // 8 command rises plus 4 read rises; the last read leaves D9=1 on TP_DO.
      cs_low();
      applyStimulus(8'hD0, 8);
      applyStimulus(8'h00, 4);
      cs_high();
      checks++;
      if (done_cnt !== 0) begin
         errors++; $display("[TB] FAIL abort_done: got %0d expected 0", done_cnt);
      end
      checks++;
      if (TP_DO !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_do: got %b expected 0", TP_DO);
      end
      checks++;
      if (oCmd !== 8'hD0) begin
         errors++; $display("[TB] FAIL abort_cmd_full: got %h expected d0", oCmd);
      end
      TP_CLK = 1'b0;
      wait_cycles(4);
      cs_low();
      do_cmd(8'h90, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (rd !== 16'h0918) begin
         errors++; $display("[TB] FAIL abort_next_read: got %h expected 0918", rd);
      end
      // A partial control byte must leave oCmd untouched.
      cs_low();
      applyStimulus(8'hD8, 5);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (oCmd !== 8'h90) begin
         errors++; $display("[TB] FAIL abort_cmd_partial: got %h expected 90", oCmd);
      end
      wait_cycles(4);
   endtask

   task automatic test_random();
      logic [15:0] rd;
      logic [15:0] exp_rd;
      logic [7:0]  cmd;
      int          exp_rise;
      for (int n = 0; n < 10; n++) begin
         iX  = 12'($urandom);
         iY  = 12'($urandom);
         cmd = 8'($urandom) | 8'h80;
         if (n % 3 == 0) cmd[6:4] = 3'b101;
         if (n % 3 == 1) cmd[6:4] = 3'b001;
         exp_rd   = model_read(cmd, iX, iY);
         exp_rise = model_done_rise(cmd);
         done_cnt = 0;
         cs_low();
         do_cmd(cmd, (n % 2) == 1, rd);
         cs_high();
         TP_CLK = 1'b0;
         checks++;
         if (rd !== exp_rd) begin
            errors++;
            $display("[TB] FAIL rand_read cmd=%h: got %h expected %h", cmd, rd, exp_rd);
         end
         checks++;
         if (oCmd !== cmd) begin
            errors++; $display("[TB] FAIL rand_cmd: got %h expected %h", oCmd, cmd);
         end
         checks++;
         if (done_cnt !== 1 || done_rise !== exp_rise) begin
            errors++;
            $display("[TB] FAIL rand_done cmd=%h: got %0d pulses at rise %0d expected 1 at %0d",
                     cmd, done_cnt, done_rise, exp_rise);
         end
         wait_cycles(2);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd;
      iX = 12'hA5C;
      iPress = 1'b1;
      cs_low();
      // Command plus null bit plus D11: TP_DO is 1 when reset hits.
      applyStimulus(8'hD0, 8);
      applyStimulus(8'h00, 2);
      RESET = 1'b0;
      wait_cycles(1);
      checks++;
      if (TP_DO !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_do: got %b expected 0", TP_DO);
      end
      checks++;
      if (TP_IRQ !== 1'b1) begin
         errors++; $display("[TB] FAIL midreset_irq: got %b expected 1", TP_IRQ);
      end
      checks++;
      if (oCmd !== 8'h00) begin
         errors++; $display("[TB] FAIL midreset_cmd: got %h expected 00", oCmd);
      end
      checks++;
      if (oDone !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_done: got %b expected 0", oDone);
      end
      TP_CS_N = 1'b1;
      TP_CLK  = 1'b0;
      iPress  = 1'b0;
      wait_cycles(4);
      RESET = 1'b1;
      wait_cycles(4);
      cs_low();
      do_cmd(8'hD0, 1'b0, rd);
      cs_high();
      TP_CLK = 1'b0;
      checks++;
      if (rd !== 16'h52E0) begin
         errors++; $display("[TB] FAIL midreset_read: got %h expected 52e0", rd);
      end
      checks++;
      if (oCmd !== 8'hD0) begin
         errors++; $display("[TB] FAIL midreset_cmd_after: got %h expected d0", oCmd);
      end
   endtask

   // Scenario sequence; each task drives and checks its own feature.
   initial begin
      errors     = 0;
      checks     = 0;
      done_cnt   = 0;
      done_rise  = 0;
      frame_rise = 0;
      test_reset();
      test_basic();
      test_irq();
      test_modes();
      test_leading_zeros();
      test_back_to_back();
      test_abort();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
